// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered PIC-style ALU with STATUS flags (C, DC, Z), a
//            valid/ready handshake and a multi-cycle N-bit rotate through carry.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    input  logic             flag_we,
    input  logic [2:0]       flag_wdata,
    output logic             c_flag,
    output logic             dc_flag,
    output logic             z_flag
);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_ROT  = 1'b1;

    localparam logic [3:0] c_OP_MOV  = 4'd0;
    localparam logic [3:0] c_OP_SWAP = 4'd1;
    localparam logic [3:0] c_OP_CLR  = 4'd2;
    localparam logic [3:0] c_OP_IOR  = 4'd3;
    localparam logic [3:0] c_OP_AND  = 4'd4;
    localparam logic [3:0] c_OP_XOR  = 4'd5;
    localparam logic [3:0] c_OP_COMF = 4'd6;
    localparam logic [3:0] c_OP_ADD  = 4'd7;
    localparam logic [3:0] c_OP_SUB  = 4'd8;
    localparam logic [3:0] c_OP_INC  = 4'd9;
    localparam logic [3:0] c_OP_DEC  = 4'd10;
    localparam logic [3:0] c_OP_RLF  = 4'd11;
    localparam logic [3:0] c_OP_RRF  = 4'd12;
    localparam logic [3:0] c_OP_RLFN = 4'd13;
    localparam logic [3:0] c_OP_RRFN = 4'd14;
    localparam logic [3:0] c_OP_MOV2 = 4'd15;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_out_valid;
    logic             r_c;
    logic             r_dc;
    logic             r_z;
    logic [WIDTH-1:0] r_rot_val;
    logic             r_rot_c;
    logic             r_rot_left;
    logic [SHW-1:0]   r_rot_cnt;

    logic             w_accept;
    logic             w_start_rot;
    logic [WIDTH-1:0] w_bb;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [4:0]       w_nib;
    logic [WIDTH-1:0] w_swap;
    logic [WIDTH-1:0] w_res;
    logic             w_alu_c;
    logic             w_alu_dc;
    logic             w_upd_c;
    logic             w_upd_dc;
    logic             w_upd_z;
    logic [WIDTH-1:0] w_rot_val_nxt;
    logic             w_rot_c_nxt;

    assign in_ready    = (r_state == c_S_IDLE) && (!r_out_valid || out_ready) && !rst;
    assign w_accept    = in_valid && in_ready;
    assign w_start_rot = ((op == c_OP_RLFN) || (op == c_OP_RRFN)) && (shamt != '0);

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign c_flag    = r_c;
    assign dc_flag   = r_dc;
    assign z_flag    = r_z;

    // All four arithmetic ops share one WIDTH+1 adder; operand B and carry-in are selected here.
    always_comb begin
        w_bb  = op_b;
        w_cin = 1'b0;
        case (op)
            c_OP_SUB: begin
                w_bb  = ~op_b;
                w_cin = 1'b1;
            end
            c_OP_INC: begin
                w_bb  = '0;
                w_cin = 1'b1;
            end
            c_OP_DEC: w_bb = '1;
            default:  w_bb = op_b;
        endcase
    end

    assign w_sum = {1'b0, op_a} + {1'b0, w_bb} + {{WIDTH{1'b0}}, w_cin};
    assign w_nib = {1'b0, op_a[3:0]} + {1'b0, w_bb[3:0]} + {4'b0000, w_cin};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH / 8; gi++) begin : g_swap
            assign w_swap[8*gi +: 8] = {op_a[8*gi +: 4], op_a[8*gi+4 +: 4]};
        end
    endgenerate

    always_comb begin
        w_res    = op_a;
        w_alu_c  = r_c;
        w_alu_dc = r_dc;
        w_upd_c  = 1'b0;
        w_upd_dc = 1'b0;
        w_upd_z  = 1'b1;
        case (op)
            c_OP_MOV, c_OP_MOV2: w_res = op_a;
            c_OP_SWAP: w_res = w_swap;
            c_OP_CLR:  w_res = '0;
            c_OP_IOR:  w_res = op_a | op_b;
            c_OP_AND:  w_res = op_a & op_b;
            c_OP_XOR:  w_res = op_a ^ op_b;
            c_OP_COMF: w_res = ~op_a;
            c_OP_ADD, c_OP_SUB, c_OP_INC, c_OP_DEC: begin
                w_res    = w_sum[WIDTH-1:0];
                w_alu_c  = w_sum[WIDTH];
                w_alu_dc = w_nib[4];
                w_upd_c  = 1'b1;
                w_upd_dc = 1'b1;
            end
            c_OP_RLF: begin
                w_res   = {op_a[WIDTH-2:0], r_c};
                w_alu_c = op_a[WIDTH-1];
                w_upd_c = 1'b1;
                w_upd_z = 1'b0;
            end
            c_OP_RRF: begin
                w_res   = {r_c, op_a[WIDTH-1:1]};
                w_alu_c = op_a[0];
                w_upd_c = 1'b1;
                w_upd_z = 1'b0;
            end
            default: begin
                // Zero-count N-bit rotate: operand passes through, C rewritten with itself.
                w_res   = op_a;
                w_alu_c = r_c;
                w_upd_c = 1'b1;
                w_upd_z = 1'b0;
            end
        endcase
    end

    assign w_rot_val_nxt = r_rot_left ? {r_rot_val[WIDTH-2:0], r_rot_c}
                                      : {r_rot_c, r_rot_val[WIDTH-1:1]};
    assign w_rot_c_nxt   = r_rot_left ? r_rot_val[WIDTH-1] : r_rot_val[0];

    // Later non-blocking writes to the flags override the direct STATUS write on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_c         <= 1'b0;
            r_dc        <= 1'b0;
            r_z         <= 1'b0;
            r_rot_val   <= '0;
            r_rot_c     <= 1'b0;
            r_rot_left  <= 1'b0;
            r_rot_cnt   <= '0;
        end else begin
            if (flag_we) begin
                r_c  <= flag_wdata[2];
                r_dc <= flag_wdata[1];
                r_z  <= flag_wdata[0];
            end
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        if (w_start_rot) begin
                            r_rot_val  <= op_a;
                            r_rot_c    <= r_c;
                            r_rot_left <= (op == c_OP_RLFN);
                            r_rot_cnt  <= shamt;
                            r_state    <= c_S_ROT;
                        end else begin
                            r_result    <= w_res;
                            r_out_valid <= 1'b1;
                            if (w_upd_c)  r_c  <= w_alu_c;
                            if (w_upd_dc) r_dc <= w_alu_dc;
                            if (w_upd_z)  r_z  <= (w_res == '0);
                        end
                    end
                end
                c_S_ROT: begin
                    r_rot_val <= w_rot_val_nxt;
                    r_rot_c   <= w_rot_c_nxt;
                    r_rot_cnt <= r_rot_cnt - SHW'(1);
                    if (r_rot_cnt == SHW'(1)) begin
                        r_result    <= w_rot_val_nxt;
                        r_c         <= w_rot_c_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Scoreboard bench for alu_seq with directed cases and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    localparam int WIDTH = 8;
    localparam int SHW   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       op = '0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic [SHW-1:0]   shamt = '0;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_we;
    logic [2:0]       flag_wdata;
    logic             c_flag, dc_flag, z_flag;

    logic       rand_bg = 1'b0;
    logic       bg_out_ready = 1'b1, dir_out_ready = 1'b1;
    logic       bg_flag_we = 1'b0, dir_flag_we = 1'b0;
    logic [2:0] bg_wdata = '0, dir_wdata = '0;

    assign out_ready  = rand_bg ? bg_out_ready : dir_out_ready;
    assign flag_we    = rand_bg ? bg_flag_we : dir_flag_we;
    assign flag_wdata = rand_bg ? bg_wdata : dir_wdata;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op_a(op_a), .op_b(op_b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_we(flag_we), .flag_wdata(flag_wdata),
        .c_flag(c_flag), .dc_flag(dc_flag), .z_flag(z_flag)
    );

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    // Reference model state: architectural flags, held-result flag, pending rotate.
    bit m_c = 0, m_dc = 0, m_z = 0, m_ov = 0;
    int m_rem = 0;
    int m_rot_res = 0;
    bit m_rot_c = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Rotate the (WIDTH+1)-bit value {C, A} by k positions.
    function automatic void rot_ref(input int a, input bit cin, input bit left, input int k,
                                    output int res, output bit cout);
        int n, s, v, mask;
        n    = WIDTH + 1;
        s    = k % n;
        mask = (1 << n) - 1;
        v    = (int'(cin) << WIDTH) | a;
        if (s != 0)
            v = left ? (((v << s) | (v >> (n - s))) & mask) : (((v >> s) | (v << (n - s))) & mask);
        res  = v & ((1 << WIDTH) - 1);
        cout = ((v >> WIDTH) & 1) != 0;
    endfunction

    function automatic void alu_ref(input int o, input int a, input int b, output int res,
                                    output bit c, output bit dc, output bit arith);
        res = a; c = 0; dc = 0; arith = 0;
        case (o)
            1:  res = ((a << 4) | (a >> 4)) & 255;
            2:  res = 0;
            3:  res = a | b;
            4:  res = a & b;
            5:  res = a ^ b;
            6:  res = 255 - a;
            7:  begin res = a + b;             dc = (a % 16) + (b % 16) >= 16;            arith = 1; end
            8:  begin res = a + (255 - b) + 1; dc = (a % 16) + (15 - (b % 16)) + 1 >= 16; arith = 1; end
            9:  begin res = a + 1;             dc = (a % 16) + 1 >= 16;                   arith = 1; end
            10: begin res = a + 255;           dc = (a % 16) + 15 >= 16;                  arith = 1; end
            default: res = a;
        endcase
        if (arith) begin
            c   = res >= 256;
            res = res % 256;
        end
    endfunction

    always @(posedge clk) begin : p_model
        bit rdy, nc, ndc, nz, wr, rc, ac, adc, ar;
        int wres, o;
        if (rst) begin
            m_c = 0; m_dc = 0; m_z = 0; m_ov = 0; m_rem = 0;
            exp_q.delete();
        end else begin
            o   = int'(op);
            rdy = (m_rem == 0) && (!m_ov || out_ready);
            {nc, ndc, nz} = flag_we ? flag_wdata : {m_c, m_dc, m_z};
            wr   = 0;
            wres = 0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    wr = 1; wres = m_rot_res; nc = m_rot_c;
                end
            end else if (in_valid && rdy) begin
                if ((o == 13 || o == 14) && shamt != 0) begin
                    rot_ref(int'(op_a), m_c, o == 13, int'(shamt), m_rot_res, m_rot_c);
                    m_rem = int'(shamt);
                end else if (o >= 11 && o <= 14) begin
                    rot_ref(int'(op_a), m_c, (o == 11) || (o == 13), (o <= 12) ? 1 : 0, wres, rc);
                    nc = rc; wr = 1;
                end else begin
                    alu_ref(o, int'(op_a), int'(op_b), wres, ac, adc, ar);
                    if (ar) begin nc = ac; ndc = adc; end
                    nz = (wres == 0);
                    wr = 1;
                end
            end
            m_c = nc; m_dc = ndc; m_z = nz;
            if (wr) begin
                exp_q.push_back(wres);
                m_ov = 1;
            end else if (out_ready) begin
                m_ov = 0;
            end
        end
    end

    // Monitor: handshake/flag checks every cycle, result popped on each transfer.
    always @(negedge clk) begin : p_monitor
        int e;
        chk("in_ready", in_ready, !rst && (m_rem == 0) && (!m_ov || out_ready));
        chk("out_valid", out_valid, m_ov);
        chk("flags", {c_flag, dc_flag, z_flag}, {m_c, m_dc, m_z});
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("result", result, e);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        bg_out_ready = ($urandom_range(0, 3) != 0);
        bg_flag_we   = ($urandom_range(0, 9) == 0);
        bg_wdata     = 3'($urandom_range(0, 7));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] k);
        int n;
        in_valid = 1'b1; op = o; op_a = a; op_b = b; shamt = k;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("handshake_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a = 8'($urandom);
        op_b = 8'($urandom);
    endtask

    task automatic set_flags(input logic [2:0] f);
        dir_flag_we = 1'b1;
        dir_wdata   = f;
        @(posedge clk);
        #1;
        dir_flag_we = 1'b0;
    endtask

    task automatic expect_now(input string name, input logic [7:0] r, input logic [2:0] f);
        chk({name, "_result"}, result, r);
        chk({name, "_flags"}, {c_flag, dc_flag, z_flag}, f);
        chk({name, "_valid"}, out_valid, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, 0);
        chk("reset_flags", {c_flag, dc_flag, z_flag}, 0);
        chk("reset_valid", out_valid, 0);
        rst = 1'b0;
        #1;
        chk("post_reset_ready", in_ready, 1);

        issue(4'd7, 8'h3A, 8'hC6, 4'd0);
        expect_now("add", 8'h00, 3'b111);
        issue(4'd8, 8'h05, 8'h07, 4'd0);
        expect_now("sub", 8'hFE, 3'b000);
        issue(4'd10, 8'h00, 8'h00, 4'd0);
        expect_now("dec", 8'hFF, 3'b000);
        set_flags(3'b100);
        issue(4'd1, 8'hA5, 8'h00, 4'd0);
        expect_now("swap", 8'h5A, 3'b100);

        set_flags(3'b000);
        issue(4'd13, 8'h81, 8'h00, 4'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rlfn_busy", in_ready, 0);
        end
        @(posedge clk);
        #1;
        expect_now("rlfn", 8'h0A, 3'b000);

        set_flags(3'b100);
        issue(4'd12, 8'h01, 8'h00, 4'd0);
        expect_now("rrf", 8'h80, 3'b100);

        issue(4'd7, 8'h10, 8'h20, 4'd0);
        dir_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_now("bp_hold", 8'h30, 3'b000);
        chk("bp_ready", in_ready, 0);
        dir_out_ready = 1'b1;
        issue(4'd5, 8'h0F, 8'hFF, 4'd0);
        expect_now("bp_next", 8'hF0, 3'b000);

        set_flags(3'b110);
        issue(4'd13, 8'h33, 8'h00, 4'd5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_flags", {c_flag, dc_flag, z_flag}, 0);
        rst = 1'b0;

        dir_flag_we = 1'b1;
        dir_wdata   = 3'b110;
        issue(4'd4, 8'h0F, 8'hF0, 4'd0);
        dir_flag_we = 1'b0;
        expect_now("and_fwe", 8'h00, 3'b111);

        rand_bg = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            issue(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 4'($urandom_range(0, 12)));
        end
        rand_bg = 1'b0;
        dir_out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
